// File: rtl/tug_key_conditioner.sv
// Conditions the two raw active-low tug-of-war keys into debounced levels and
// single-cycle press pulses (L/R) for the score stage.
module tug_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic l_level,
  output logic r_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the left channel, index 1 the right channel.
  logic [1:0]       key_n;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       level_p2;
  logic [1:0]       pulse_p2;
  logic [CNT_W-1:0] cnt_p2 [2];

  assign key_n = {key_r_n, key_l_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      level_p2 <= '0;
      pulse_p2 <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_p2[ch] <= '0;
      end
    end else begin
      // Stage p0/p1: two-flop synchroniser, inverted to 1 = pressed.
      sync_p0 <= ~key_n;
      sync_p1 <= sync_p0;
      // Stage p2: debounce run counter, accepted level and press pulse.
      for (int ch = 0; ch < 2; ch++) begin
        pulse_p2[ch] <= 1'b0;
        if (sync_p1[ch] == level_p2[ch]) begin
          cnt_p2[ch] <= '0;
        end else if (cnt_p2[ch] != CNT_LAST) begin
          cnt_p2[ch] <= cnt_p2[ch] + CNT_W'(1);
        end else begin
          level_p2[ch] <= sync_p1[ch];
          cnt_p2[ch]   <= '0;
          // Only a press that lands while the round is live ever scores.
          pulse_p2[ch] <= sync_p1[ch] & ~freeze;
        end
      end
    end
  end

  assign L       = pulse_p2[0];
  assign R       = pulse_p2[1];
  assign l_level = level_p2[0];
  assign r_level = level_p2[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Self-checking bench for tug_key_conditioner: directed scenarios followed by
// random key bouncing, compared against a history-based reference model.
module tb_tug_key_conditioner;

  localparam int D     = 4;
  localparam int MAX_E = 4096;

  logic clk;
  logic reset;
  logic key_l_n;
  logic key_r_n;
  logic freeze;
  logic L;
  logic R;
  logic l_level;
  logic r_level;

  int checks;
  int failures;

  // Model: raw pressed value sampled at each edge, plus reset/change history.
  bit raw_h [2][MAX_E];
  int n_edge;
  int last_reset;
  int last_change [2];
  bit m_level [2];
  bit m_pulse [2];
  int l_cnt;
  int r_cnt;

  tug_key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .freeze  (freeze),
    .L       (L),
    .R       (R),
    .l_level (l_level),
    .r_level (r_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronised value the debouncer sees at edge k: the raw sample two edges
  // earlier, or released if that sample predates the last reset.
  function automatic bit seen(int ch, int k);
    if (k - 2 > last_reset) return raw_h[ch][k-2];
    return 1'b0;
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, n_edge, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit frz;
    bit rst;
    bit all_diff;
    @(posedge clk);
    n_edge++;
    raw_h[0][n_edge] = ~key_l_n;
    raw_h[1][n_edge] = ~key_r_n;
    frz = freeze;
    rst = reset;
    for (int ch = 0; ch < 2; ch++) begin
      m_pulse[ch] = 1'b0;
      if (rst) begin
        m_level[ch]     = 1'b0;
        last_change[ch] = n_edge;
      end else if (n_edge - D >= last_change[ch]) begin
        all_diff = 1'b1;
        for (int k = n_edge - D + 1; k <= n_edge; k++)
          if (seen(ch, k) == m_level[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[ch]     = ~m_level[ch];
          last_change[ch] = n_edge;
          m_pulse[ch]     = m_level[ch] & ~frz;
        end
      end
    end
    if (rst) last_reset = n_edge;
    #1;
    check("L", L, m_pulse[0]);
    check("R", R, m_pulse[1]);
    check("l_level", l_level, m_level[0]);
    check("r_level", r_level, m_level[1]);
    l_cnt += int'(L);
    r_cnt += int'(R);
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    n_edge      = 0;
    last_reset  = 0;
    l_cnt       = 0;
    r_cnt       = 0;
    for (int ch = 0; ch < 2; ch++) begin
      last_change[ch] = 0;
      m_level[ch]     = 1'b0;
      m_pulse[ch]     = 1'b0;
    end
    reset   = 1'b1;
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    freeze  = 1'b0;

    // Reset with keys released.
    run(2);
    reset = 1'b0;
    run(4);

    // Single left press held 20 cycles: one pulse, R silent.
    l_cnt = 0; r_cnt = 0;
    key_l_n = 1'b0; run(20);
    check_int("press_l_pulses", l_cnt, 1);
    check_int("press_l_r_pulses", r_cnt, 0);
    key_l_n = 1'b1; run(10);

    // Bounce then hold.
    l_cnt = 0;
    key_l_n = 1'b0; run(2);
    key_l_n = 1'b1; run(1);
    key_l_n = 1'b0; run(1);
    key_l_n = 1'b1; run(1);
    key_l_n = 1'b0; run(12);
    check_int("bounce_pulses", l_cnt, 1);
    key_l_n = 1'b1; run(10);

    // Hold, release, press again: two pulses.
    l_cnt = 0;
    key_l_n = 1'b0; run(30);
    key_l_n = 1'b1; run(10);
    key_l_n = 1'b0; run(12);
    check_int("repress_pulses", l_cnt, 2);
    key_l_n = 1'b1; run(10);

    // Simultaneous presses.
    l_cnt = 0; r_cnt = 0;
    key_l_n = 1'b0; key_r_n = 1'b0; run(10);
    check_int("simul_l", l_cnt, 1);
    check_int("simul_r", r_cnt, 1);
    key_l_n = 1'b1; key_r_n = 1'b1; run(10);

    // Frozen press, then unfreeze while held: no pulse.
    r_cnt = 0;
    freeze = 1'b1; key_r_n = 1'b0; run(10);
    freeze = 1'b0; run(6);
    check_int("freeze_r_pulses", r_cnt, 0);
    key_r_n = 1'b1; run(10);

    // Reset mid-debounce with key held through it.
    r_cnt = 0;
    key_r_n = 1'b0; run(4);
    reset = 1'b1; run(1);
    reset = 1'b0; run(10);
    check_int("reset_mid_pulses", r_cnt, 1);
    key_r_n = 1'b1; run(10);

    // Random bouncing keys, occasional freeze toggles and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) key_l_n = ~key_l_n;
      if ($urandom_range(7) == 0) key_r_n = ~key_r_n;
      if ($urandom_range(40) == 0) freeze = ~freeze;
      reset = ($urandom_range(150) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
